// File: rtl/seg_reg_bank.sv
// seg_reg_bank: CHANNELS x WIDTH display register bank with addressed write, combinational
// read-back and a free-running scan engine driving a shared segment bus plus one-hot digit select.
// Latency: RdData combinational; ScanSeg/ScanSel/FrameTick registered, 1 cycle after idx/bank.
// Backpressure: none. Writes are always accepted; out-of-range addresses are dropped.
// Optional: define SEG_REG_BANK_BLINK_EN to add the BlinkMask input and a frame-counted blink phase.
module seg_reg_bank #(
    parameter int unsigned       WIDTH     = 7,
    parameter int unsigned       CHANNELS  = 4,
    parameter int unsigned       SCAN_DIV  = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}},
    localparam int unsigned      AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                WrEn,
    input  logic [AW-1:0]       WrAddr,
    input  logic [WIDTH-1:0]    WrData,
    input  logic [AW-1:0]       RdAddr,
    output logic [WIDTH-1:0]    RdData,
    input  logic                Blank,
    output logic [WIDTH-1:0]    ScanSeg,
    output logic [CHANNELS-1:0] ScanSel,
    output logic                FrameTick
`ifdef SEG_REG_BANK_BLINK_EN
    ,
    input  logic [CHANNELS-1:0] BlinkMask
`endif
);

    localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [AW:0] CH_LIM = (AW+1)'(CHANNELS);

    logic [WIDTH-1:0]    bank [CHANNELS];
    logic [PW-1:0]       pre;
    logic [AW-1:0]       idx;
    logic                pre_last;
    logic                idx_last;
    logic                wrap_q;
    logic                blink_off;
    logic [CHANNELS-1:0] sel_onehot;

    assign pre_last   = (pre == PW'(SCAN_DIV - 1));
    assign idx_last   = (idx == AW'(CHANNELS - 1));
    assign sel_onehot = CHANNELS'(1) << idx;

    // Bank update: only in-range addresses write; every other entry holds.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                bank[i] <= RESET_VAL;
            end
        end else if (WrEn && ({1'b0, WrAddr} < CH_LIM)) begin
            bank[WrAddr] <= WrData;
        end
    end

    // Read-back is a plain mux; out-of-range addresses read as the reset pattern.
    always_comb begin
        RdData = RESET_VAL;
        if ({1'b0, RdAddr} < CH_LIM) begin
            RdData = bank[RdAddr];
        end
    end

    // Prescaler holds each channel for SCAN_DIV cycles, then steps idx with wrap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre_last) begin
            pre <= '0;
            idx <= idx_last ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

`ifdef SEG_REG_BANK_BLINK_EN
    localparam int unsigned BLINK_DIV = 32;
    localparam int unsigned BW        = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt;

    // Frame counter for blinking; its MSB is the blink phase.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            blink_cnt <= '0;
        end else if (FrameTick) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = blink_cnt[BW-1] & BlinkMask[idx];
`else
    assign blink_off = 1'b0;
`endif

    // Pin register: segment bus and digit select lag idx/bank by one cycle;
    // FrameTick is delayed once more so it coincides with channel 0 on the pins.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ScanSeg   <= RESET_VAL;
            ScanSel   <= '0;
            wrap_q    <= 1'b0;
            FrameTick <= 1'b0;
        end else begin
            wrap_q    <= pre_last & idx_last;
            FrameTick <= wrap_q;
            if (Blank) begin
                ScanSeg <= RESET_VAL;
                ScanSel <= '0;
            end else begin
                ScanSeg <= blink_off ? RESET_VAL : bank[idx];
                ScanSel <= sel_onehot;
            end
        end
    end

endmodule

// File: tb/tb_seg_reg_bank.sv
// tb_seg_reg_bank: randomized + directed stimulus against a time-based reference model;
// expected pin values are queued per clock edge and compared by an independent monitor.
// A second 3-channel instance covers out-of-range write/read addressing.
module tb_seg_reg_bank;

    localparam int SD = 4;
    localparam int C  = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       WrEn = 1'b0;
    logic [1:0] WrAddr = '0;
    logic [6:0] WrData = '0;
    logic [1:0] RdAddr = '0;
    logic [6:0] RdData;
    logic       Blank = 1'b0;
    logic [6:0] ScanSeg;
    logic [3:0] ScanSel;
    logic       FrameTick;

    logic       c3_en = 1'b0;
    logic [1:0] c3_addr = '0;
    logic [6:0] c3_data = '0;
    logic [1:0] c3_rd = '0;
    logic [6:0] c3_rdata;
    logic [6:0] c3_seg;
    logic [2:0] c3_sel;
    logic       c3_ft;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       ft;
    } exp_t;

    exp_t       sbq[$];
    logic [6:0] mbank [C];
    int         edges  = 0;
    int         total  = 0;
    int         passed = 0;

    always #10 Clock = ~Clock;

    seg_reg_bank #(.WIDTH(7), .CHANNELS(4), .SCAN_DIV(SD)) dut (
        .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddr(RdAddr), .RdData(RdData), .Blank(Blank), .ScanSeg(ScanSeg),
        .ScanSel(ScanSel), .FrameTick(FrameTick)
`ifdef SEG_REG_BANK_BLINK_EN
        , .BlinkMask(4'b0000)
`endif
    );

    seg_reg_bank #(.WIDTH(7), .CHANNELS(3), .SCAN_DIV(SD)) dut3 (
        .Clock(Clock), .Reset(Reset), .WrEn(c3_en), .WrAddr(c3_addr), .WrData(c3_data),
        .RdAddr(c3_rd), .RdData(c3_rdata), .Blank(1'b0), .ScanSeg(c3_seg),
        .ScanSel(c3_sel), .FrameTick(c3_ft)
`ifdef SEG_REG_BANK_BLINK_EN
        , .BlinkMask(3'b000)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock of stimulus: drive at the falling edge, queue what the pins must show
    // after the next rising edge, then fold the write into the model bank.
    task automatic step(input logic en, input logic [1:0] a, input logic [6:0] d, input logic bl);
        exp_t e;
        int   cur;
        @(negedge Clock);
        WrEn = en; WrAddr = a; WrData = d; Blank = bl;
        RdAddr = 2'($urandom_range(0, 3));
        #1;
        chk("rddata", RdData, mbank[RdAddr]);
        cur   = (edges / SD) % C;
        e.sel = bl ? 4'b0000 : 4'(1 << cur);
        e.seg = bl ? 7'h7F : mbank[cur];
        e.ft  = (edges >= 1) && (edges % (SD * C) == 0);
        sbq.push_back(e);
        if (en) mbank[a] = d;
        edges++;
    endtask

    // Asynchronous reset asserted between edges; values must change with no clock.
    task automatic do_reset();
        @(posedge Clock);
        #2 Reset = 1'b1;
        WrEn = 1'b0; Blank = 1'b0;
        #1;
        chk("rst_seg", ScanSeg, 7'h7F);
        chk("rst_sel", ScanSel, 4'b0000);
        chk("rst_ft", FrameTick, 1'b0);
        for (int a = 0; a < C; a++) begin
            RdAddr = 2'(a);
            #1 chk("rst_rd", RdData, 7'h7F);
        end
        #1 Reset = 1'b0;
        for (int i = 0; i < C; i++) mbank[i] = 7'h7F;
        edges = 0;
        sbq.delete();
    endtask

    // Monitor: the pins are valid every cycle after reset; compare one step after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("scanseg", ScanSeg, e.seg);
                chk("scansel", ScanSel, e.sel);
                chk("frametick", FrameTick, e.ft);
            end
        end
    end

    // 3-channel build: address 3 is out of range for both write and read.
    initial begin
        logic [6:0] vals [4];
        vals[0] = 7'h11; vals[1] = 7'h22; vals[2] = 7'h33; vals[3] = 7'h55;
        wait (Reset === 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            c3_en = 1'b1; c3_addr = 2'(i); c3_data = vals[i];
        end
        @(negedge Clock);
        c3_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c3_rd = 2'(i);
            #1 chk("c3_rd", c3_rdata, (i < 3) ? vals[i] : 7'h7F);
        end
    end

    initial begin
        for (int i = 0; i < C; i++) mbank[i] = 7'h7F;
        do_reset();

        // Addressed writes, then watch a full frame plus margin.
        step(1, 2'd0, 7'h40, 0);
        step(1, 2'd1, 7'h79, 0);
        step(1, 2'd2, 7'h24, 0);
        step(1, 2'd3, 7'h30, 0);
        for (int i = 0; i < 20; i++) step(0, 2'd0, 7'h00, 0);

        // Write to channel 1 while it is the one being scanned.
        for (int g = 0; g < 64 && ((edges / SD) % C) != 1; g++) step(0, 2'd0, 7'h00, 0);
        step(1, 2'd1, 7'h12, 0);
        for (int i = 0; i < 6; i++) step(0, 2'd0, 7'h00, 0);

        // Blank for 10 cycles; scan position keeps advancing underneath.
        for (int i = 0; i < 10; i++) step(0, 2'd0, 7'h00, 1);
        for (int i = 0; i < 10; i++) step(0, 2'd0, 7'h00, 0);

        // Write channel 2 on the very edge idx advances 1 -> 2.
        for (int g = 0; g < 64 && !((edges % SD == SD - 1) && ((edges / SD) % C == 1)); g++)
            step(0, 2'd0, 7'h00, 0);
        step(1, 2'd2, 7'h5A, 0);
        for (int i = 0; i < 6; i++) step(0, 2'd0, 7'h00, 0);

        // Reset in the middle of a scan, then randomized traffic.
        do_reset();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), 7'($urandom),
                 $urandom_range(0, 9) == 0);

        @(posedge Clock);
        #2 chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
